sipo_rx: RTL

SIPO_RX -- requirements
Module: sipo_rx

---
 rtl/sipo_pkg.sv | 13 +
 rtl/sipo_bitcnt.sv | 32 +++
 rtl/sipo_rx.sv | 94 +++++++++
 3 files changed

// File: rtl/sipo_pkg.sv
// Shared constants and state encoding for the serial-in parallel-out receiver.
// Imported by the bit counter and the receiver top.
package sipo_pkg;

   localparam int SIPO_W  = 4;
   localparam int SIPO_CW = $clog2(SIPO_W);

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

endpackage

// File: rtl/sipo_bitcnt.sv
// Modulo-N bit counter with enable, synchronous clear and terminal count.
// tc flags the enabled cycle that wraps the count back to zero.
module sipo_bitcnt
   import sipo_pkg::*;
#(
   parameter int N  = SIPO_W,
   parameter int CW = SIPO_CW
) (
   input  logic clk,
   input  logic reset,
   input  logic en,
   input  logic clr,
   output logic tc
);

   localparam logic [CW-1:0] LAST = CW'(N - 1);

   logic [CW-1:0] cnt;

   assign tc = en & ~clr & (cnt == LAST);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= tc ? '0 : cnt + 1'b1;
      end
   end

endmodule

// File: rtl/sipo_rx.sv
// MSB-first serial receiver with a one-word holding register.
// Collection never stalls; a word finishing while the holder is full is dropped.
module sipo_rx
   import sipo_pkg::*;
#(
   parameter int W = SIPO_W
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         sin,
   input  logic         sin_en,
   input  logic         flush,
   output logic [W-1:0] dout,
   output logic         dout_valid,
   input  logic         dout_ready,
   output logic         overrun,
   output logic         busy
);

   localparam int CW = $clog2(W);

   state_t       state;
   state_t       state_nx;
   logic [W-1:0] shreg;
   logic [W-1:0] word;
   logic         acc;
   logic         tc;
   logic         take;

   assign acc  = sin_en & ~flush;
   assign word = {shreg[W-2:0], sin};
   assign take = ~dout_valid | dout_ready;

   sipo_bitcnt #(
      .N  (W),
      .CW (CW)
   ) u_bitcnt (
      .clk   (clk),
      .reset (reset),
      .en    (sin_en),
      .clr   (flush),
      .tc    (tc)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:    if (acc) state_nx = SHIFT;
         SHIFT:   if (flush || tc) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      busy = (state == SHIFT);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         shreg <= '0;
      end else if (flush) begin
         shreg <= '0;
      end else if (sin_en) begin
         shreg <= word;
      end
   end

   // Handshake and completion in one cycle: the new word replaces the old.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         dout       <= '0;
         dout_valid <= 1'b0;
         overrun    <= 1'b0;
      end else if (tc) begin
         if (take) begin
            dout       <= word;
            dout_valid <= 1'b1;
         end else begin
            overrun    <= 1'b1;
         end
      end else if (dout_ready) begin
         dout_valid <= 1'b0;
      end
   end

endmodule
